// File: rtl/mult8_err_accum.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mult8_err_accum: scores 8x8 multiplier products against the exact result.   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module mult8_err_accum #(
  parameter int CNT_W = 32,
  parameter int SUM_W = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             start,
  input  logic [CNT_W-1:0] target,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic [15:0]      in_p,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] samples,
  output logic [CNT_W-1:0] mismatches,
  output logic [SUM_W-1:0] sum_abs_err,
  output logic             sum_sat,
  output logic [15:0]      max_abs_err,
  output logic [7:0]       max_err_a,
  output logic [7:0]       max_err_b
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_target;
  logic [CNT_W-1:0] r_count;
  logic             r_s1_valid;
  logic [7:0]       r_s1_a;
  logic [7:0]       r_s1_b;
  logic [15:0]      r_s1_p;

  logic [15:0]      w_exact;
  logic [15:0]      w_err;
  logic [SUM_W:0]   w_sum_ext;
  logic             w_accept;
  logic             w_last;
  logic             w_start_ok;

  assign w_exact    = {8'd0, r_s1_a} * {8'd0, r_s1_b};
  assign w_err      = (r_s1_p >= w_exact) ? (r_s1_p - w_exact) : (w_exact - r_s1_p);
  // One extra bit catches the carry that signals saturation.
  assign w_sum_ext  = {1'b0, sum_abs_err} + {{(SUM_W-15){1'b0}}, w_err};
  assign w_accept   = (r_state == ST_RUN) && in_valid;
  assign w_last     = ((r_count + CNT_W'(1)) == r_target);
  assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_target    <= '0;
      r_count     <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_s1_p      <= '0;
      in_ready    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      samples     <= '0;
      mismatches  <= '0;
      sum_abs_err <= '0;
      sum_sat     <= 1'b0;
      max_abs_err <= '0;
      max_err_a   <= '0;
      max_err_b   <= '0;
    end else if (clear) begin
      r_state     <= ST_IDLE;
      r_target    <= '0;
      r_count     <= '0;
      r_s1_valid  <= 1'b0;
      in_ready    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      samples     <= '0;
      mismatches  <= '0;
      sum_abs_err <= '0;
      sum_sat     <= 1'b0;
      max_abs_err <= '0;
      max_err_a   <= '0;
      max_err_b   <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_a <= in_a;
        r_s1_b <= in_b;
        r_s1_p <= in_p;
      end

      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_target <= target;
            r_count  <= '0;
            if (target != '0) begin
              r_state  <= ST_RUN;
              in_ready <= 1'b1;
              busy     <= 1'b1;
              done     <= 1'b0;
            end else begin
              r_state  <= ST_DONE;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (w_accept) begin
            r_count <= r_count + CNT_W'(1);
            if (w_last) begin
              r_state  <= ST_DRAIN;
              in_ready <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          r_state <= ST_DONE;
          busy    <= 1'b0;
          done    <= 1'b1;
        end
        default: begin
          r_state  <= ST_IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase

      // Stage 2: the pipeline is always empty in IDLE/DONE, so start never races an update.
      if (w_start_ok) begin
        samples     <= '0;
        mismatches  <= '0;
        sum_abs_err <= '0;
        sum_sat     <= 1'b0;
        max_abs_err <= '0;
        max_err_a   <= '0;
        max_err_b   <= '0;
      end else if (r_s1_valid) begin
        samples <= samples + CNT_W'(1);
        if (w_err != 16'd0) begin
          mismatches <= mismatches + CNT_W'(1);
        end
        if (w_sum_ext[SUM_W]) begin
          sum_abs_err <= '1;
          sum_sat     <= 1'b1;
        end else begin
          sum_abs_err <= w_sum_ext[SUM_W-1:0];
        end
        if (w_err > max_abs_err) begin
          max_abs_err <= w_err;
          max_err_a   <= r_s1_a;
          max_err_b   <= r_s1_b;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult8_err_accum.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mult8_err_accum: scoreboard bench for the multiplier error accumulator.  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_mult8_err_accum;

  localparam int     CNT_W   = 32;
  localparam int     SUM_W   = 17;
  localparam longint SUM_MAX = (64'd1 << SUM_W) - 1;

  logic             clk      = 1'b0;
  logic             rst_n    = 1'b0;
  logic             clear    = 1'b0;
  logic             start    = 1'b0;
  logic [CNT_W-1:0] target   = '0;
  logic             in_valid = 1'b0;
  logic [7:0]       in_a     = '0;
  logic [7:0]       in_b     = '0;
  logic [15:0]      in_p     = '0;
  logic             in_ready, busy, done, sum_sat;
  logic [CNT_W-1:0] samples, mismatches;
  logic [SUM_W-1:0] sum_abs_err;
  logic [15:0]      max_abs_err;
  logic [7:0]       max_err_a, max_err_b;

  mult8_err_accum #(.CNT_W(CNT_W), .SUM_W(SUM_W)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .start(start), .target(target),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_p(in_p),
    .busy(busy), .done(done), .samples(samples), .mismatches(mismatches),
    .sum_abs_err(sum_abs_err), .sum_sat(sum_sat), .max_abs_err(max_abs_err),
    .max_err_a(max_err_a), .max_err_b(max_err_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          due;
    int unsigned samples;
    int unsigned mism;
    longint      sum;
    bit          sat;
    int          max;
    int          a;
    int          b;
  } exp_t;

  exp_t exp_q[$];

  int unsigned m_samples, m_mism;
  longint      m_sum;
  bit          m_sat;
  int          m_max, m_a, m_b;

  task automatic model_zero();
    m_samples = 0; m_mism = 0; m_sum = 0; m_sat = 0; m_max = 0; m_a = 0; m_b = 0;
    exp_q.delete();
  endtask

  // Drives one cycle from a negedge; pushes the expected running stats for an accepted
  // triple and checks every entry whose result is due after this edge.
  task automatic drive_cycle(input logic v, input logic [7:0] a, input logic [7:0] b,
                             input logic [15:0] p);
    logic acc;
    exp_t e;
    int   ex, err;
    in_valid = v; in_a = a; in_b = b; in_p = p;
    acc = v && in_ready;
    @(posedge clk); #1;
    if (acc) begin
      ex  = int'(a) * int'(b);
      err = (int'(p) > ex) ? int'(p) - ex : ex - int'(p);
      m_samples++;
      if (err != 0) m_mism++;
      if (m_sum + err > SUM_MAX) begin m_sum = SUM_MAX; m_sat = 1; end
      else m_sum += err;
      if (err > m_max) begin m_max = err; m_a = a; m_b = b; end
      e.due = cyc + 1; e.samples = m_samples; e.mism = m_mism; e.sum = m_sum;
      e.sat = m_sat; e.max = m_max; e.a = m_a; e.b = m_b;
      exp_q.push_back(e);
    end
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      e = exp_q.pop_front();
      checks++;
      if (samples !== e.samples || mismatches !== e.mism || sum_abs_err !== e.sum ||
          sum_sat !== e.sat || max_abs_err !== e.max || max_err_a !== e.a || max_err_b !== e.b) begin
        errors++;
        $display("FAIL scoreboard @%0d: got s=%0d m=%0d sum=%0d sat=%0d max=%0d a=%0d b=%0d, want s=%0d m=%0d sum=%0d sat=%0d max=%0d a=%0d b=%0d",
                 cyc, samples, mismatches, sum_abs_err, sum_sat, max_abs_err, max_err_a, max_err_b,
                 e.samples, e.mism, e.sum, e.sat, e.max, e.a, e.b);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic flush();
    for (int k = 0; k < 4 && exp_q.size() > 0; k++) drive_cycle(1'b0, 8'd0, 8'd0, 16'd0);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL flush_timeout: %0d results still pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_start(input logic [CNT_W-1:0] t);
    start = 1'b1; target = t;
    @(posedge clk); #1;
    start = 1'b0;
    model_zero();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, busy, done, sum_sat} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags: got rdy/busy/done/sat=%b, required 0000", {in_ready, busy, done, sum_sat});
    end
    checks++;
    if (samples !== '0 || mismatches !== '0 || sum_abs_err !== '0 || max_abs_err !== '0 ||
        max_err_a !== '0 || max_err_b !== '0) begin
      errors++;
      $display("FAIL reset_stats: got s=%0d m=%0d sum=%0d max=%0d, required all 0",
               samples, mismatches, sum_abs_err, max_abs_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_exact();
    do_start(3);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL exact_run_state: got rdy=%b busy=%b done=%b, required 1 1 0", in_ready, busy, done);
    end
    drive_cycle(1'b1, 8'd3, 8'd5, 16'd15);
    drive_cycle(1'b1, 8'd255, 8'd255, 16'd65025);
    drive_cycle(1'b1, 8'd0, 8'd200, 16'd0);
    flush();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || samples !== 3 || mismatches !== 0 ||
        sum_abs_err !== 0 || max_abs_err !== 0) begin
      errors++;
      $display("FAIL exact_final: got done=%b busy=%b s=%0d m=%0d sum=%0d max=%0d, required 1 0 3 0 0 0",
               done, busy, samples, mismatches, sum_abs_err, max_abs_err);
    end
  endtask

  task automatic test_errors();
    do_start(3);
    drive_cycle(1'b1, 8'd15, 8'd15, 16'd200);
    drive_cycle(1'b0, 8'd1, 8'd1, 16'd9);
    drive_cycle(1'b1, 8'd255, 8'd255, 16'd65025);
    drive_cycle(1'b0, 8'd2, 8'd2, 16'd9);
    drive_cycle(1'b1, 8'd16, 8'd16, 16'd300);
    flush();
    checks++;
    if (done !== 1'b1 || mismatches !== 2 || sum_abs_err !== 69 || max_abs_err !== 44 ||
        max_err_a !== 16 || max_err_b !== 16) begin
      errors++;
      $display("FAIL errors_final: got done=%b m=%0d sum=%0d max=%0d a=%0d b=%0d, required 1 2 69 44 16 16",
               done, mismatches, sum_abs_err, max_abs_err, max_err_a, max_err_b);
    end
  endtask

  task automatic test_tie();
    do_start(2);
    drive_cycle(1'b1, 8'd2, 8'd3, 16'd16);
    drive_cycle(1'b1, 8'd5, 8'd2, 16'd20);
    flush();
    checks++;
    if (max_abs_err !== 10 || max_err_a !== 2 || max_err_b !== 3 || sum_abs_err !== 20) begin
      errors++;
      $display("FAIL tie_final: got max=%0d a=%0d b=%0d sum=%0d, required 10 2 3 20",
               max_abs_err, max_err_a, max_err_b, sum_abs_err);
    end
  endtask

  task automatic test_saturate();
    do_start(3);
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 8'd0, 8'd0, 16'd65535);
    flush();
    checks++;
    if (sum_abs_err !== 131071 || sum_sat !== 1'b1 || mismatches !== 3) begin
      errors++;
      $display("FAIL saturate_final: got sum=%0d sat=%b m=%0d, required 131071 1 3",
               sum_abs_err, sum_sat, mismatches);
    end
  endtask

  task automatic test_control();
    do_start(0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0 || samples !== 0 || sum_sat !== 1'b0) begin
      errors++;
      $display("FAIL zero_target: got done=%b busy=%b rdy=%b s=%0d sat=%b, required 1 0 0 0 0",
               done, busy, in_ready, samples, sum_sat);
    end
    do_start(4);
    drive_cycle(1'b1, 8'd7, 8'd9, 16'd60);
    start = 1'b1; target = 9;
    drive_cycle(1'b1, 8'd11, 8'd13, 16'd143);
    start = 1'b0;
    for (int i = 0; i < 6; i++) drive_cycle(1'b1, 8'(i + 20), 8'd3, 16'(i));
    flush();
    checks++;
    if (in_ready !== 1'b0 || done !== 1'b1 || samples !== 4) begin
      errors++;
      $display("FAIL overrun_guard: got rdy=%b done=%b s=%0d, required 0 1 4", in_ready, done, samples);
    end
  endtask

  task automatic test_abort();
    do_start(5);
    drive_cycle(1'b1, 8'd4, 8'd4, 16'd20);
    drive_cycle(1'b1, 8'd6, 8'd6, 16'd30);
    in_valid = 1'b1; in_a = 8'd9; in_b = 8'd9; in_p = 16'd1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, busy, done, sum_sat} !== 4'b0 || samples !== 0 || mismatches !== 0 ||
        sum_abs_err !== 0 || max_abs_err !== 0 || max_err_a !== 0 || max_err_b !== 0) begin
      errors++;
      $display("FAIL async_abort: got rdy=%b busy=%b done=%b s=%0d m=%0d sum=%0d max=%0d, required all 0",
               in_ready, busy, done, samples, mismatches, sum_abs_err, max_abs_err);
    end
    model_zero();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_start(5);
    drive_cycle(1'b1, 8'd3, 8'd3, 16'd1);
    drive_cycle(1'b1, 8'd10, 8'd10, 16'd7);
    in_valid = 1'b1; in_a = 8'd1; in_b = 8'd1; in_p = 16'd99;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    exp_q.delete();
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0 || samples !== 0 || sum_abs_err !== 0 ||
        max_abs_err !== 0) begin
      errors++;
      $display("FAIL clear_now: got busy=%b rdy=%b done=%b s=%0d sum=%0d max=%0d, required all 0",
               busy, in_ready, done, samples, sum_abs_err, max_abs_err);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (samples !== 0 || mismatches !== 0 || sum_abs_err !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_inflight_dropped: got s=%0d m=%0d sum=%0d busy=%b, required 0 0 0 0",
               samples, mismatches, sum_abs_err, busy);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_exact();
    test_errors();
    test_tie();
    test_saturate();
    test_control();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
